// File: rtl/boot_loader.sv
// Byte-serial program loader: receives a framed image (LE word count, MSB-first
// payload words, XOR checksum byte), writes each word to memory at consecutive
// word addresses from BASE_ADDR, then releases the CPU on a good checksum.
// Ports:
//   clk_in     - clock, rising edge
//   pc_reset   - asynchronous active-low reset
//   rx_data    - stream byte
//   rx_valid   - rx_data valid
//   rx_ready   - loader accepts a byte (transfer on rx_valid & rx_ready)
//   mem_addr   - memory write address
//   mem_wdata  - memory write data
//   mem_wr     - one-cycle memory write strobe
//   cpu_hold   - 1 holds the CPU in reset
//   done       - sticky, image loaded and checksum matched
//   error      - sticky, frame rejected
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk_in,
    input  logic        pc_reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 16;

    typedef enum logic [2:0] {
        ST_HDR   = 3'd0,
        ST_DATA  = 3'd1,
        ST_WRITE = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] nwords_q, nwords_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [7:0]    csum_q, csum_d;
    logic          rx_ready_q, rx_ready_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          cpu_hold_q, cpu_hold_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic          xfer;
    logic [AW-1:0] hdr_n;
    logic [AW-1:0] idx_next_ext;

    assign xfer         = rx_valid & rx_ready_q;
    // Little-endian header: each new byte enters at the top and shifts down.
    assign hdr_n        = {rx_data, nwords_q[31:8]};
    assign idx_next_ext = AW'(idx_q) + 32'd1;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        idx_d       = idx_q;
        nwords_d    = nwords_q;
        wdata_d     = wdata_q;
        csum_d      = csum_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    nwords_d   = hdr_n;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if ((hdr_n != 32'd0) && (hdr_n <= 32'(MAX_WORDS))) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ERR;
                        end
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wdata_d    = {wdata_q[23:0], rx_data};
                    csum_d     = csum_q ^ rx_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d     = ST_WRITE;
                        mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        mem_wdata_d = {wdata_q[23:0], rx_data};
                    end
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + 16'd1;
                if (idx_next_ext < nwords_q) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_HDR;
        endcase

        // Outputs are registered from the upcoming state so they align with it.
        rx_ready_d = (state_d == ST_HDR) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        mem_wr_d   = (state_d == ST_WRITE);
        cpu_hold_d = (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
        error_d    = (state_d == ST_ERR);
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge pc_reset) begin
        if (!pc_reset) begin
            state_q     <= ST_HDR;
            byte_cnt_q  <= 2'd0;
            idx_q       <= 16'd0;
            nwords_q    <= 32'd0;
            wdata_q     <= 32'd0;
            csum_q      <= 8'd0;
            rx_ready_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= 32'd0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            idx_q       <= idx_d;
            nwords_q    <= nwords_d;
            wdata_q     <= wdata_d;
            csum_q      <= csum_d;
            rx_ready_q  <= rx_ready_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: frame loads, framing errors, stalls and reset.
module tb_boot_loader;

    logic        clk_in;
    logic        pc_reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic        prev_wr = 1'b0;

    boot_loader #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(256)
    ) dut (
        .clk_in   (clk_in),
        .pc_reset (pc_reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr   (mem_wr),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Write monitor: records writes, checks strobe width and rx_ready in WRITE.
    always @(negedge clk_in) begin
        if (pc_reset === 1'b1 && mem_wr === 1'b1) begin
            n_checks++;
            if (rx_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_rx_ready: rx_ready=%b during write, expected 0", rx_ready);
            end
            n_checks++;
            if (prev_wr) begin
                n_fail++;
                $display("FAIL wr_width: mem_wr high two cycles in a row, expected one");
            end
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        prev_wr = (mem_wr === 1'b1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        t = 0;
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_data  = b;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk_in);
            t++;
        end
        if (t >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: rx_ready stayed %b for byte %h, expected 1", rx_ready, b);
        end
        @(posedge clk_in);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
        for (int g = 0; g < gap; g++) begin
            @(posedge clk_in);
            #1;
            rx_data = 8'($urandom);
        end
    endtask

    task automatic send_hdr(input logic [31:0] n, input int gap);
        for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], gap);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        pc_reset = 1'b0;
        rx_valid = 1'b0;
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        repeat (2) @(negedge clk_in);
        pc_reset = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic check_end(input string name, input logic exp_done, input int exp_wr);
        @(negedge clk_in);
        n_checks++;
        if (done !== exp_done) begin
            n_fail++;
            $display("FAIL %s_done: got %b expected %b", name, done, exp_done);
        end
        n_checks++;
        if (error !== !exp_done) begin
            n_fail++;
            $display("FAIL %s_error: got %b expected %b", name, error, !exp_done);
        end
        n_checks++;
        if (cpu_hold !== !exp_done) begin
            n_fail++;
            $display("FAIL %s_cpu_hold: got %b expected %b", name, cpu_hold, !exp_done);
        end
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rx_ready: got %b expected 0", name, rx_ready);
        end
        n_checks++;
        if (wr_addr_q.size() != exp_wr) begin
            n_fail++;
            $display("FAIL %s_wr_count: got %0d expected %0d", name, wr_addr_q.size(), exp_wr);
        end
    endtask

    task automatic check_wr(input string name, input int i, input logic [31:0] a, input logic [31:0] d);
        n_checks++;
        if (i >= wr_addr_q.size()) begin
            n_fail++;
            $display("FAIL %s_wr%0d: missing write, expected addr %h data %h", name, i, a, d);
        end else if (wr_addr_q[i] !== a || wr_data_q[i] !== d) begin
            n_fail++;
            $display("FAIL %s_wr%0d: got addr %h data %h expected addr %h data %h",
                     name, i, wr_addr_q[i], wr_data_q[i], a, d);
        end
    endtask

    task automatic test_reset();
        pc_reset = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if ({rx_ready, mem_wr, cpu_hold, done, error} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/wr/hold/done/err=%b expected 00100",
                     {rx_ready, mem_wr, cpu_hold, done, error});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr %h data %h expected 0 0", mem_addr, mem_wdata);
        end
        pc_reset = 1'b1;
        #1;
        n_checks++;
        if (rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rdy_early: got %b expected 0", rx_ready);
        end
        @(negedge clk_in);
        n_checks++;
        if (rx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rdy_rise: got %b expected 1", rx_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        send_hdr(32'd1, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        @(negedge clk_in);
        n_checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL single_latency: got wr %b addr %h data %h expected 1 0 12345678",
                     mem_wr, mem_addr, mem_wdata);
        end
        n_checks++;
        if (cpu_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL single_hold_pre: got %b expected 1", cpu_hold);
        end
        send_byte(8'h08, 0);
        n_checks++;
        if (cpu_hold !== 1'b0 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL single_release: got hold %b done %b expected 0 1", cpu_hold, done);
        end
        check_end("single", 1'b1, 1);
        check_wr("single", 0, 32'h0, 32'h1234_5678);
    endtask

    task automatic test_toggle();
        do_reset();
        send_hdr(32'd3, 1);
        send_word(32'hDEAD_BEEF, 1);
        send_word(32'h0102_0304, 1);
        send_word(32'hA5A5_5A5A, 1);
        send_byte(8'h26, 1);
        check_end("toggle", 1'b1, 3);
        check_wr("toggle", 0, 32'h0, 32'hDEAD_BEEF);
        check_wr("toggle", 1, 32'h4, 32'h0102_0304);
        check_wr("toggle", 2, 32'h8, 32'hA5A5_5A5A);
    endtask

    task automatic test_bad_hdr(input string name, input logic [31:0] n);
        do_reset();
        send_hdr(n, 0);
        check_end(name, 1'b0, 0);
        repeat (5) @(negedge clk_in);
        n_checks++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || mem_wr !== 1'b0 || wr_addr_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_sticky: got err %b hold %b writes %0d expected 1 1 0",
                     name, error, cpu_hold, wr_addr_q.size());
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        send_hdr(32'd2, 0);
        send_word(32'h1122_3344, 0);
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'h8C, 0);
        check_end("badcsum", 1'b0, 2);
        check_wr("badcsum", 0, 32'h0, 32'h1122_3344);
        check_wr("badcsum", 1, 32'h4, 32'hCAFE_F00D);
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_hdr(32'd2, 0);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        @(negedge clk_in);
        pc_reset = 1'b0;
        #1;
        n_checks++;
        if (cpu_hold !== 1'b1 || rx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: got hold %b rdy %b expected 1 0", cpu_hold, rx_ready);
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk_in);
        pc_reset = 1'b1;
        @(negedge clk_in);
        send_hdr(32'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'hC9, 0);
        check_end("midrst", 1'b1, 1);
        check_wr("midrst", 0, 32'h0, 32'hCAFE_F00D);
    endtask

    task automatic test_max_words();
        logic [7:0] b;
        do_reset();
        send_hdr(32'd256, 0);
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_word({b, b, b, b}, 0);
        end
        send_byte(8'h00, 0);
        check_end("maxw", 1'b1, 256);
        check_wr("maxw", 1, 32'h4, 32'h0101_0101);
        check_wr("maxw", 255, 32'h3FC, 32'hFFFF_FFFF);
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_bad_hdr("n0", 32'd0);
        test_bad_hdr("n257", 32'd257);
        test_bad_csum();
        test_mid_reset();
        test_max_words();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Byte-serial program loader that sits directly upstream of the single-cycle CPU and its unified Memory. After reset it holds the CPU in reset, accepts a framed program image over a valid/ready byte stream, and writes each 32-bit word into Memory at consecutive word addresses. It verifies a checksum, then releases the CPU to execute from `BASE_ADDR`. It latches an error and keeps the CPU held if the frame is malformed.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address of the first program word; must be word-aligned.
- `MAX_WORDS`, default 256: largest accepted word count; legal range 1..2^16.
- `clk_in` input 1: single clock; all state changes on its rising edge.
- `pc_reset` input 1: asynchronous, active-low reset (0 = reset asserted).
- `rx_data` input 8: incoming stream byte.
- `rx_valid` input 1: `rx_data` is valid.
- `rx_ready` output 1: loader can accept a byte. A byte is transferred on any edge where `rx_valid & rx_ready`.
- `mem_addr` output 32: write address to Memory.
- `mem_wdata` output 32: write data to Memory.
- `mem_wr` output 1: one-cycle write strobe.
- `cpu_hold` output 1: drives the CPU's PC reset; 1 = CPU held.
- `done` output 1: load completed and checksum passed; sticky.
- `error` output 1: frame rejected; sticky.

## Operation
- Frame format, in stream order:
  - Header: 4 bytes, little-endian word count N.
  - Payload: N words, each 4 bytes, most-significant byte first.
  - Checksum: 1 byte, equal to the XOR of all 4N payload bytes. The header is not covered.
- States:
  - HDR: `rx_ready`=1. Counts header bytes 0..3. When byte 3 is accepted, the assembled N (including that byte) is checked. If 1 ≤ N ≤ `MAX_WORDS`, go to DATA; otherwise go to ERR.
  - DATA: `rx_ready`=1. Shifts bytes into the word register: `wdata = {wdata[23:0], rx_data}`. XORs each byte into the checksum accumulator. On the 4th byte of a word, go to WRITE.
  - WRITE: `rx_ready`=0. `mem_wr`=1 for exactly one cycle with `mem_addr` = `BASE_ADDR` + 4·idx and `mem_wdata` = assembled word. Then idx increments. Go to DATA if idx+1 < N, else go to CSUM.
  - CSUM: `rx_ready`=1. On the accepted byte, go to DONE if the byte equals the accumulator, else go to ERR.
  - DONE: `rx_ready`=0, `cpu_hold`=0, `done`=1. Terminal state.
  - ERR: `rx_ready`=0, `cpu_hold`=1, `error`=1. Terminal state.
- DONE and ERR are left only through `pc_reset`.
- idx is a 16-bit counter. The byte counter is 2 bits and wraps 3→0 at each word boundary. Address arithmetic is 32-bit and never wraps within a legal N.
- Words already written before an ERR are not rolled back.
- `mem_addr` and `mem_wdata` are don't-care whenever `mem_wr`=0. They are registered and held stable during WRITE.

## Timing
- Reset values (asynchronous, immediate on `pc_reset`=0): state=HDR, `rx_ready`=0, `mem_wr`=0, `mem_addr`=`BASE_ADDR`, `mem_wdata`=0, `cpu_hold`=1, `done`=0, `error`=0, all counters and the accumulator = 0.
- `rx_ready` rises one cycle after `pc_reset` deasserts. All outputs are registered.
- Word write latency: `mem_wr` is high in the cycle immediately after the edge that accepted the word's 4th byte. Each word therefore costs at least 5 cycles.
- `cpu_hold` falls and `done` rises in the cycle after the edge that accepts a correct checksum byte.
- The CPU's first fetch occurs on the following edge.
- `rx_valid` may drop at any time. The loader waits in the current state with no side effects, and counters advance only on transfers.
- `rx_data` is ignored when no transfer occurs.
- Reset mid-frame (any state) aborts immediately. `cpu_hold` returns to 1, and the next frame starts from header byte 0.

## Test plan
- N=1, payload 12 34 56 78, checksum 0x08 → one `mem_wr` with addr 0x0, data 0x12345678. Then `cpu_hold`=0 and `done`=1 one cycle after the checksum byte.
- N=3 with `rx_valid` toggled every other cycle → writes to 0x0, 0x4, 0x8 in order, each `mem_wr` exactly one cycle wide, and `rx_ready`=0 during every WRITE cycle.
- Header N=0 → `error`=1 after the 4th header byte, no `mem_wr` ever, `cpu_hold` stays 1, `rx_ready`=0.
- Header N=`MAX_WORDS`+1 (257) → same response as N=0.
- N=2 with a wrong checksum byte (correct value XOR 0x01) → two writes occur, then `error`=1, `done`=0, `cpu_hold`=1.
- `pc_reset` pulsed low after 6 payload bytes of N=2, then a full valid N=1 frame sent → exactly one write, to 0x0, with the new data, and `done`=1.
